// File: rtl/program_streamer.sv
// ---------------------------------------------------------------------------
// program_streamer
//
// Holds a small program memory of instruction words and shifts a selected
// number of them out serially, MSB first, one bit per clock.  The serial
// bit and its enable drive a processor's load port (inReg[0] / en).
//
// Ports
//   clk       in   rising-edge clock
//   reset     in   asynchronous active-low reset (clears memory too)
//   wr_en     in   write strobe for program memory (ignored while streaming)
//   wr_addr   in   word address for writes
//   wr_data   in   instruction word to store
//   prog_len  in   words to stream, sampled with start (0 or >depth = depth)
//   start     in   begin a stream when idle
//   abort     in   stop an active stream at once, no done pulse
//   load_en   out  high while a bit is presented on load_bit
//   load_bit  out  serial instruction bit, 0 whenever load_en is low
//   busy      out  high while streaming
//   done      out  single-cycle pulse after the last bit of a full stream
//   word_idx  out  word currently being sent
//   bit_idx   out  bit position currently on load_bit
// ---------------------------------------------------------------------------
module program_streamer #(
    parameter int INSTRUCTION_LENGTH = 13,
    parameter int PROG_DEPTH         = 16,
    localparam int AW = $clog2(PROG_DEPTH),
    localparam int LW = $clog2(PROG_DEPTH + 1),
    localparam int BW = $clog2(INSTRUCTION_LENGTH)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          wr_en,
    input  logic [AW-1:0]                 wr_addr,
    input  logic [INSTRUCTION_LENGTH-1:0] wr_data,
    input  logic [LW-1:0]                 prog_len,
    input  logic                          start,
    input  logic                          abort,
    output logic                          load_en,
    output logic                          load_bit,
    output logic                          busy,
    output logic                          done,
    output logic [AW-1:0]                 word_idx,
    output logic [BW-1:0]                 bit_idx
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [BW-1:0] MSB = BW'(INSTRUCTION_LENGTH - 1);

    // Index of the final word; out-of-range lengths mean the whole memory.
    function automatic logic [AW-1:0] last_word(input logic [LW-1:0] len);
        if (len == '0 || len > LW'(PROG_DEPTH))
            return AW'(PROG_DEPTH - 1);
        else
            return AW'(len - LW'(1));
    endfunction

    logic [INSTRUCTION_LENGTH-1:0] mem_q [PROG_DEPTH];

    state_t          state_q, state_d;
    logic [AW-1:0]   last_q, last_d;
    logic [AW-1:0]   word_q, word_d;
    logic [BW-1:0]   bit_q, bit_d;
    logic            en_q, en_d;
    logic            lbit_q, lbit_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;

    // The memory is frozen during SEND, so the next bit can be fetched
    // combinationally and registered alongside its indices.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        word_d  = word_q;
        bit_d   = bit_q;
        en_d    = 1'b0;
        lbit_d  = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                word_d = '0;
                bit_d  = MSB;
                // abort has priority over start
                if (start && !abort) begin
                    state_d = S_SEND;
                    last_d  = last_word(prog_len);
                    en_d    = 1'b1;
                    busy_d  = 1'b1;
                    lbit_d  = mem_q[0][MSB];
                end
            end
            S_SEND: begin
                if (abort) begin
                    state_d = S_IDLE;
                    word_d  = '0;
                    bit_d   = MSB;
                end else if (bit_q == '0) begin
                    if (word_q == last_q) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                        word_d  = '0;
                        bit_d   = MSB;
                    end else begin
                        word_d  = word_q + AW'(1);
                        bit_d   = MSB;
                        en_d    = 1'b1;
                        busy_d  = 1'b1;
                        lbit_d  = mem_q[word_q + AW'(1)][MSB];
                    end
                end else begin
                    bit_d  = bit_q - BW'(1);
                    en_d   = 1'b1;
                    busy_d = 1'b1;
                    lbit_d = mem_q[word_q][bit_q - BW'(1)];
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                word_d  = '0;
                bit_d   = MSB;
            end
            default: begin
                state_d = S_IDLE;
                word_d  = '0;
                bit_d   = MSB;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            last_q  <= '0;
            word_q  <= '0;
            bit_q   <= MSB;
            en_q    <= 1'b0;
            lbit_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            for (int i = 0; i < PROG_DEPTH; i++)
                mem_q[i] <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            word_q  <= word_d;
            bit_q   <= bit_d;
            en_q    <= en_d;
            lbit_q  <= lbit_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            // Writes are locked out only while a stream is in flight.
            if (wr_en && state_q != S_SEND)
                mem_q[wr_addr] <= wr_data;
        end
    end

    assign load_en  = en_q;
    assign load_bit = lbit_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign word_idx = word_q;
    assign bit_idx  = bit_q;

endmodule

// File: tb/tb_program_streamer.sv
// ---------------------------------------------------------------------------
// tb_program_streamer
//
// Directed bench for program_streamer: single/double word streams, a full
// default-length stream, abort, mid-stream asynchronous reset, and writes /
// start pulses attempted while busy.
// ---------------------------------------------------------------------------
module tb_program_streamer;

    logic        clk = 1'b0;
    logic        reset;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [12:0] wr_data;
    logic [4:0]  prog_len;
    logic        start;
    logic        abort;
    logic        load_en;
    logic        load_bit;
    logic        busy;
    logic        done;
    logic [3:0]  word_idx;
    logic [3:0]  bit_idx;

    program_streamer dut (
        .clk      (clk),
        .reset    (reset),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .prog_len (prog_len),
        .start    (start),
        .abort    (abort),
        .load_en  (load_en),
        .load_bit (load_bit),
        .busy     (busy),
        .done     (done),
        .word_idx (word_idx),
        .bit_idx  (bit_idx)
    );

    always #5 clk = ~clk;

    int err_cnt = 0;
    int chk_cnt = 0;

    logic [12:0] exp_mem [16];
    bit          cap [$];
    int          n_en, n_done, done_at, run_len, run_max, idx_bad, idle_bad;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; return 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_word(input logic [3:0] a, input logic [12:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        tick();
        wr_en   = 1'b0;
    endtask

    // Start a stream and observe ncyc cycles beginning with the first bit.
    // abort_at / inject (cycle numbers, -1 for none) drive abort, or a
    // start pulse plus a write of 0 to word 0, during that cycle.
    task automatic run_stream(input logic [4:0] len, input int ncyc,
                              input int abort_at, input int inject);
        cap.delete();
        n_en = 0; n_done = 0; done_at = -1; run_len = 0; run_max = 0;
        idx_bad = 0; idle_bad = 0;
        prog_len = len;
        start    = 1'b1;
        tick();
        start    = 1'b0;
        for (int c = 0; c < ncyc; c++) begin
            if (load_en) begin
                if (word_idx != 4'(n_en / 13) || bit_idx != 4'(12 - n_en % 13) || !busy)
                    idx_bad++;
                cap.push_back(load_bit);
                n_en++;
                run_len++;
                if (run_len > run_max) run_max = run_len;
            end else begin
                run_len = 0;
                if (load_bit || busy || word_idx != 4'd0 || bit_idx != 4'd12)
                    idle_bad++;
            end
            if (done) begin
                n_done++;
                if (done_at < 0) done_at = c;
            end
            if (c == abort_at) abort = 1'b1;
            if (c == inject) begin
                start   = 1'b1;
                wr_en   = 1'b1;
                wr_addr = 4'd0;
                wr_data = 13'h0000;
            end
            tick();
            abort = 1'b0;
            start = 1'b0;
            wr_en = 1'b0;
        end
    endtask

    // Count bit positions where the capture differs from the first
    // 'words' model words sent MSB first; a length mismatch counts too.
    function automatic int cap_errs(input int words);
        int e = 0;
        if (cap.size() != words * 13) e++;
        for (int k = 0; k < cap.size() && k < words * 13; k++)
            if (cap[k] != exp_mem[k / 13][12 - k % 13]) e++;
        return e;
    endfunction

    initial begin
        reset = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        prog_len = '0; start = 1'b0; abort = 1'b0;
        for (int i = 0; i < 16; i++) exp_mem[i] = '0;

        // Reset state
        #12;
        chk("rst_load_en", load_en, 0);
        chk("rst_load_bit", load_bit, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_word_idx", word_idx, 0);
        chk("rst_bit_idx", bit_idx, 12);
        @(negedge clk) reset = 1'b1;
        repeat (3) tick();
        chk("post_rst_idle", {load_en, busy, done}, 0);

        // One all-ones word
        write_word(4'd0, 13'h1FFF); exp_mem[0] = 13'h1FFF;
        run_stream(5'd1, 16, -1, -1);
        chk("w1_en_cycles", n_en, 13);
        chk("w1_contig", run_max, 13);
        chk("w1_bits", cap_errs(1), 0);
        chk("w1_done_at", done_at, 13);
        chk("w1_done_cnt", n_done, 1);
        chk("w1_idx", idx_bad, 0);
        chk("w1_idle", idle_bad, 0);
        chk("w1_busy_after", busy, 0);

        // Two alternating words
        write_word(4'd0, 13'h1555); exp_mem[0] = 13'h1555;
        write_word(4'd1, 13'h0AAA); exp_mem[1] = 13'h0AAA;
        run_stream(5'd2, 30, -1, -1);
        chk("w2_en_cycles", n_en, 26);
        chk("w2_contig", run_max, 26);
        chk("w2_bits", cap_errs(2), 0);
        chk("w2_done_at", done_at, 26);
        chk("w2_done_cnt", n_done, 1);
        chk("w2_idx", idx_bad, 0);

        // Length 0 and length 20 both mean all 16 words
        for (int i = 0; i < 16; i++) begin
            exp_mem[i] = 13'(i * 397 + 100);
            write_word(4'(i), exp_mem[i]);
        end
        run_stream(5'd0, 212, -1, -1);
        chk("w16_en_cycles", n_en, 208);
        chk("w16_contig", run_max, 208);
        chk("w16_bits", cap_errs(16), 0);
        chk("w16_done_at", done_at, 208);
        chk("w16_idx", idx_bad, 0);
        chk("w16_idle", idle_bad, 0);
        run_stream(5'd20, 212, -1, -1);
        chk("w20_en_cycles", n_en, 208);
        chk("w20_bits", cap_errs(16), 0);

        // Abort asserted during cycle 50: bits 0..50 seen, then idle
        run_stream(5'd0, 70, 50, -1);
        chk("abort_en_cycles", n_en, 51);
        chk("abort_done_cnt", n_done, 0);
        chk("abort_idle", idle_bad, 0);
        chk("abort_idx", idx_bad, 0);
        run_stream(5'd2, 30, -1, -1);
        chk("after_abort_bits", cap_errs(2), 0);
        chk("after_abort_en", n_en, 26);

        // abort and start together in idle: nothing starts
        abort = 1'b1; start = 1'b1; prog_len = 5'd1;
        tick();
        abort = 1'b0; start = 1'b0;
        chk("abort_start_busy", busy, 0);
        tick();
        chk("abort_start_en", load_en, 0);

        // Write and start attempted mid-stream are ignored
        run_stream(5'd2, 45, -1, 5);
        chk("busy_wr_en_cycles", n_en, 26);
        chk("busy_wr_bits", cap_errs(2), 0);
        chk("busy_wr_done_cnt", n_done, 1);
        run_stream(5'd1, 16, -1, -1);
        chk("busy_wr_mem0", cap_errs(1), 0);

        // Asynchronous reset between edges mid-stream
        prog_len = 5'd0; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (20) tick();
        chk("pre_rst_en", load_en, 1);
        #2 reset = 1'b0;
        #1;
        chk("arst_load_en", load_en, 0);
        chk("arst_load_bit", load_bit, 0);
        chk("arst_busy", busy, 0);
        chk("arst_idx", {word_idx, bit_idx}, {4'd0, 4'd12});
        @(negedge clk) reset = 1'b1;
        for (int i = 0; i < 16; i++) exp_mem[i] = '0;
        repeat (3) tick();
        chk("arst_no_restart", {load_en, busy, done}, 0);
        run_stream(5'd0, 212, -1, -1);
        chk("arst_mem_zero", cap_errs(16), 0);
        chk("arst_en_cycles", n_en, 208);
        chk("arst_done_cnt", n_done, 1);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

    // Overall time bound so the bench always ends.
    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule

// File: doc/program_streamer.md
PROGRAM_STREAMER -- requirements
Module: program_streamer

Interface
REQ-001: Parameter INSTRUCTION_LENGTH, default 13, bits per instruction word.
REQ-002: Parameter PROG_DEPTH, default 16, number of instruction words held.
REQ-003: clk  input  1  single clock for all sequential logic; rising edge.
REQ-004: reset  input  1  asynchronous, active-low reset.
REQ-005: wr_en  input  1  writes wr_data to program memory at wr_addr on the rising clk edge.
REQ-006: wr_addr  input  4  program memory word address, 0..15.
REQ-007: wr_data  input  13  instruction word to store.
REQ-008: prog_len  input  5  number of words to stream; sampled on start.
REQ-009: start  input  1  begins a stream when sampled high in IDLE.
REQ-010: abort  input  1  terminates an active stream.
REQ-011: load_en  output  1  drives the processor en input; high only while bits are being sent.
REQ-012: load_bit  output  1  drives processor inReg[0]; the serial instruction bit.
REQ-013: busy  output  1  high in SEND state.
REQ-014: done  output  1  one-cycle pulse after the final bit of a completed stream.
REQ-015: word_idx  output  4  index of the word currently being sent.
REQ-016: bit_idx  output  4  bit position currently on load_bit, 12..0.

Function
REQ-017: The block SHALL implement states IDLE, SEND, DONE; all outputs registered.
REQ-018: IDLE -> SEND on the edge where start=1; prog_len latched; word_idx=0, bit_idx=12.
REQ-019: Latched length: prog_len 1..16 used as-is; 0 or >16 SHALL be treated as 16.
REQ-020: In SEND, load_en=1 and load_bit=mem[word_idx][bit_idx]; first bit visible the cycle after start is sampled.
REQ-021: Bits SHALL be sent MSB first (bit 12 down to bit 0), exactly one bit per clk cycle, no gaps between words.
REQ-022: After bit_idx 0, bit_idx SHALL reload to 12 and word_idx increment by 1.
REQ-023: After bit 0 of word (length-1), next state SHALL be DONE: load_en=0, load_bit=0, busy=0, done=1 for exactly one cycle, then IDLE.
REQ-024: load_en SHALL be high for exactly length*13 consecutive cycles per completed stream.
REQ-025: load_bit SHALL be 0 whenever load_en=0.
REQ-026: start while busy or in DONE SHALL be ignored.
REQ-027: wr_en while busy SHALL be ignored (memory contents frozen during a stream); writes in IDLE/DONE take effect.
REQ-028: abort=1 in SEND SHALL return to IDLE on that edge: load_en=0, load_bit=0, busy=0, done not pulsed.
REQ-029: abort and start both high in IDLE: abort wins, no stream starts.
REQ-030: In IDLE, word_idx and bit_idx SHALL hold 0 and 12.

Reset
REQ-031: reset=0 SHALL asynchronously force IDLE, load_en=0, load_bit=0, busy=0, done=0, word_idx=0, bit_idx=12, all memory words to 0.
REQ-032: reset asserted mid-stream SHALL take effect immediately without waiting for clk; no done pulse follows.
REQ-033: After reset release, the block SHALL start no stream until a new start is sampled.

Verification
REQ-034: Write mem[0]=13'h1FFF, prog_len=1, start -> load_en high 13 cycles, load_bit all 1, done pulse on cycle 14, busy low after.
REQ-035: Write mem[0]=13'h1555, mem[1]=13'h0AAA, prog_len=2, start -> load_bit sequence 1010101010101 then 0101010101010, 26 cycles of load_en.
REQ-036: prog_len=0 with 16 distinct words -> load_en high 208 cycles, word_idx steps 0..15, captured stream equals memory MSB-first.
REQ-037: Abort at cycle 50 of a 16-word stream -> load_en=0 and busy=0 next cycle, done never pulses; subsequent start streams from word 0.
REQ-038: reset low mid-stream between clock edges -> outputs zero immediately; memory reads back 0 on next stream.
REQ-039: wr_en to mem[0] and start pulse during busy -> stream output and memory unchanged, no second stream.
